// File: rtl/router_ctrl_if.sv
// Purpose: bundles the packet-source handshake and the three-FIFO control
//          bus of the 1x3 router input controller into one interface.
// Signals:
//   pkt_valid, data_in          source byte strobe and byte
//   fifo_full, fifo_empty       status of FIFO 0..2
//   read_enb                    destination read enables of FIFO 0..2
//   busy                        back-pressure to the source
//   dout, write_enb, lfd_state  FIFO write byte, one-hot enable, header flag
//   ld_state                    payload/parity loading indicator
//   err                         parity-error pulse
//   vld_out, soft_reset         per-FIFO valid and flush pulses
// Modports: master = source/FIFO side (drives inputs of the controller),
//           slave  = router_ctrl.
interface router_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic [2:0]        fifo_full;
  logic [2:0]        fifo_empty;
  logic [2:0]        read_enb;
  logic              busy;
  logic [DATA_W-1:0] dout;
  logic [2:0]        write_enb;
  logic              lfd_state;
  logic              ld_state;
  logic              err;
  logic [2:0]        vld_out;
  logic [2:0]        soft_reset;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    input  busy, dout, write_enb, lfd_state, ld_state, err, vld_out, soft_reset
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    output busy, dout, write_enb, lfd_state, ld_state, err, vld_out, soft_reset
  );
endinterface

// File: rtl/router_ctrl.sv
// Purpose: input-side packet controller of the 1x3 router. Decodes the
//          header {len[7:2], addr[1:0]}, sequences writes of header, payload
//          and parity into one of three FIFOs, back-pressures the source,
//          checks the trailing parity byte, drops packets for address 3 and
//          flushes FIFOs whose reader has stalled for TIMEOUT cycles.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   router_ctrl_if slave modport (handshake, FIFO control, status)
module router_ctrl #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 30,
  parameter int TO_W    = 5
) (
  input  logic         clk,
  input  logic         rst,
  router_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EMPTY,
    LOAD_DATA,
    LOAD_PARITY,
    DROP
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        addr_q, addr_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] par_q, par_d;
  logic              err_q, err_d;
  logic [2:0]        soft_q;
  logic [2:0][TO_W-1:0] to_q;

  logic              busy;
  logic              wr;
  logic              lfd;
  logic              accept;
  logic [1:0]        wr_addr;
  logic [DATA_W-1:0] dout;
  logic [1:0]        hdr_addr;
  logic [5:0]        hdr_len;

  assign hdr_addr = bus.data_in[1:0];
  assign hdr_len  = bus.data_in[7:2];

  // Next-state and combinational outputs. While rst is high every
  // combinational output is held at its idle value so the source and FIFOs
  // see a quiet bus immediately, not only after the state register clears.
  // A header written straight from IDLE targets the address on data_in; all
  // other writes target the latched address.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    par_d   = par_q;
    err_d   = 1'b0;
    busy    = 1'b0;
    wr      = 1'b0;
    lfd     = 1'b0;
    accept  = 1'b0;
    dout    = bus.data_in;
    wr_addr = (state_q == IDLE) ? hdr_addr : addr_q;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          accept = bus.pkt_valid;
          if (accept) begin
            addr_d = hdr_addr;
            hold_d = bus.data_in;
            par_d  = bus.data_in;
            if (hdr_addr == 2'd3) begin
              // Payload plus parity byte are consumed without writing.
              cnt_d   = {1'b0, hdr_len} + 7'd1;
              state_d = DROP;
            end else begin
              cnt_d = {1'b0, hdr_len};
              if (bus.fifo_empty[hdr_addr]) begin
                wr      = 1'b1;
                lfd     = 1'b1;
                state_d = (hdr_len == 6'd0) ? LOAD_PARITY : LOAD_DATA;
              end else begin
                state_d = WAIT_EMPTY;
              end
            end
          end
        end
        WAIT_EMPTY: begin
          busy = 1'b1;
          if (bus.fifo_empty[addr_q] && !bus.fifo_full[addr_q]) begin
            wr      = 1'b1;
            lfd     = 1'b1;
            dout    = hold_q;
            state_d = (cnt_q == 7'd0) ? LOAD_PARITY : LOAD_DATA;
          end
        end
        LOAD_DATA: begin
          busy   = bus.fifo_full[addr_q];
          accept = bus.pkt_valid && !busy;
          if (accept) begin
            wr    = 1'b1;
            par_d = par_q ^ bus.data_in;
            cnt_d = cnt_q - 7'd1;
            if (cnt_q == 7'd1) begin
              state_d = LOAD_PARITY;
            end
          end
        end
        LOAD_PARITY: begin
          busy   = bus.fifo_full[addr_q];
          accept = bus.pkt_valid && !busy;
          if (accept) begin
            wr      = 1'b1;
            err_d   = (bus.data_in != par_q);
            state_d = IDLE;
          end
        end
        DROP: begin
          accept = bus.pkt_valid;
          if (accept) begin
            cnt_d = cnt_q - 7'd1;
            if (cnt_q == 7'd1) begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Packet FSM registers: state, latched header fields, parity accumulator
  // and the registered parity-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 2'd0;
      cnt_q   <= 7'd0;
      hold_q  <= '0;
      par_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      par_q   <= par_d;
      err_q   <= err_d;
    end
  end

  // Per-port stall timeout, independent of the packet FSM. A port stalls
  // while it holds data its reader is not taking; after TIMEOUT consecutive
  // stalled cycles a single flush pulse is issued and the count restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q   <= '0;
      soft_q <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (bus.read_enb[i] || bus.fifo_empty[i]) begin
          to_q[i]   <= '0;
          soft_q[i] <= 1'b0;
        end else if (to_q[i] == TO_W'(TIMEOUT - 1)) begin
          to_q[i]   <= '0;
          soft_q[i] <= 1'b1;
        end else begin
          to_q[i]   <= to_q[i] + TO_W'(1);
          soft_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.busy       = busy;
  assign bus.dout       = dout;
  assign bus.write_enb  = wr ? (3'b001 << wr_addr) : 3'b000;
  assign bus.lfd_state  = lfd;
  assign bus.ld_state   = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY);
  assign bus.err        = err_q;
  assign bus.vld_out    = ~bus.fifo_empty;
  assign bus.soft_reset = soft_q;

endmodule

// File: tb/tb_router_ctrl.sv
// Purpose: self-checking testbench for router_ctrl. Inputs are driven on the
//          falling clock edge and outputs sampled 2 ns later, away from the
//          rising edge.
module tb_router_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  router_ctrl_if #(.DATA_W(8)) bus ();

  router_ctrl #(
    .DATA_W (8),
    .TIMEOUT(30),
    .TO_W   (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pv;
    logic [7:0] d;
    logic [2:0] empty;
    logic       busy;
    logic [2:0] we;
    logic       lfd;
    logic [2:0] vld;
  } vec_t;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
    logic       lfd;
  } wr_t;

  wr_t expQ[$];
  wr_t actQ[$];
  int  errExp  = 0;
  int  errSeen = 0;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive all inputs (called at a falling edge) and let them settle.
  task automatic applyStimulus(input logic pv, input logic [7:0] d, input logic [2:0] full,
                               input logic [2:0] empty, input logic [2:0] rd);
    bus.pkt_valid  = pv;
    bus.data_in    = d;
    bus.fifo_full  = full;
    bus.fifo_empty = empty;
    bus.read_enb   = rd;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Send header, payload 0,1,2.. and a given parity byte with pkt_valid held
  // high. Optionally hold the FIFO full for some cycles before byte stallIdx.
  task automatic runPkt(input logic [7:0] hdr, input int stallIdx, input int stallCyc,
                        input logic [7:0] parity, input logic expErr, input string tag);
    int         n;
    int         writes;
    logic [2:0] pbit;
    logic [7:0] b;
    n      = int'(hdr[7:2]);
    pbit   = 3'b001 << hdr[1:0];
    writes = 0;
    for (int i = 0; i < n + 2; i++) begin
      if (i == 0) b = hdr;
      else if (i == n + 1) b = parity;
      else b = 8'(i - 1);
      if (i == stallIdx) begin
        for (int s = 0; s < stallCyc; s++) begin
          applyStimulus(1'b1, b, pbit, ~pbit, 3'b111);
          checkOutput({tag, " stall busy"}, bus.busy, 1);
          checkOutput({tag, " stall we"}, bus.write_enb, 0);
          tick();
        end
      end
      applyStimulus(1'b1, b, 3'b000, 3'b111, 3'b111);
      checkOutput({tag, " busy"}, bus.busy, 0);
      checkOutput({tag, " we"}, bus.write_enb, pbit);
      checkOutput({tag, " lfd"}, bus.lfd_state, (i == 0));
      checkOutput({tag, " ld"}, bus.ld_state, (i != 0));
      checkOutput({tag, " dout"}, bus.dout, b);
      if (bus.write_enb != 3'b000) writes++;
      tick();
    end
    applyStimulus(1'b0, 8'h00, 3'b000, 3'b111, 3'b111);
    checkOutput({tag, " err"}, bus.err, expErr);
    checkOutput({tag, " idle ld"}, bus.ld_state, 0);
    checkOutput({tag, " write count"}, writes, n + 2);
    tick();
    applyStimulus(1'b0, 8'h00, 3'b000, 3'b111, 3'b111);
    checkOutput({tag, " err cleared"}, bus.err, 0);
    tick();
  endtask

  // Records FIFO writes and err pulses seen in the current cycle.
  task automatic monitor();
    wr_t w;
    if (bus.err) errSeen++;
    if (bus.write_enb != 3'b000) begin
      checkOutput("rand onehot", $onehot(bus.write_enb), 1);
      checkOutput("rand write while full", |(bus.write_enb & bus.fifo_full), 0);
      w.port = bus.write_enb[1] ? 2'd1 : (bus.write_enb[2] ? 2'd2 : 2'd0);
      w.data = bus.dout;
      w.lfd  = bus.lfd_state;
      actQ.push_back(w);
    end
  endtask

  // Random packets, random source gaps and random FIFO-full back-pressure.
  // The reference is packet level: every packet to ports 0..2 must appear
  // in order as header(lfd)+payload+parity on its port; bad parity on such
  // a packet yields one err pulse; address-3 packets produce nothing.
  task automatic randomTest();
    logic [7:0] pk[$];
    logic [7:0] hdr;
    logic [7:0] x;
    logic [7:0] b;
    logic [2:0] full;
    logic       pv;
    logic       badp;
    logic       done;
    int         len;
    int         addr;
    int         guard;
    wr_t        e;
    for (int p = 0; p < 40; p++) begin
      pk.delete();
      len  = $urandom_range(0, 12);
      addr = $urandom_range(0, 3);
      hdr  = {6'(len), 2'(addr)};
      x    = hdr;
      pk.push_back(hdr);
      for (int j = 0; j < len; j++) begin
        b = 8'($urandom);
        pk.push_back(b);
        x = x ^ b;
      end
      badp = ($urandom_range(0, 3) == 0);
      pk.push_back(badp ? (x ^ 8'($urandom_range(1, 255))) : x);
      if (addr != 3) begin
        for (int j = 0; j < pk.size(); j++) begin
          e.port = 2'(addr);
          e.data = pk[j];
          e.lfd  = (j == 0);
          expQ.push_back(e);
        end
        if (badp) errExp++;
      end
      for (int j = 0; j < pk.size(); j++) begin
        done  = 1'b0;
        guard = 0;
        while (!done) begin
          full = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
          pv   = ($urandom_range(0, 3) != 0);
          applyStimulus(pv, pk[j], full, ~full, 3'b111);
          monitor();
          if (pv && !bus.busy) done = 1'b1;
          tick();
          guard++;
          if (!done && guard > 300) begin
            total++;
            bad++;
            $display("[TB] FAIL rand accept bound: byte %0d of packet %0d not accepted in 300 cycles", j, p);
            return;
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 8'h00, 3'b000, 3'b111, 3'b111);
      monitor();
      tick();
    end
    checkOutput("rand write count", actQ.size(), expQ.size());
    for (int i = 0; i < actQ.size() && i < expQ.size(); i++) begin
      checkOutput($sformatf("rand write %0d", i), actQ[i], expQ[i]);
    end
    checkOutput("rand err pulses", errSeen, errExp);
  endtask

  vec_t vecs[6];

  initial begin
    // Single-cycle decode from IDLE: {pv, data, empty, busy, we, lfd, vld}.
    vecs[0] = '{1'b0, 8'h39, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000};
    vecs[1] = '{1'b1, 8'h39, 3'b111, 1'b0, 3'b010, 1'b1, 3'b000};
    vecs[2] = '{1'b1, 8'h0B, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000};
    vecs[3] = '{1'b1, 8'h0A, 3'b011, 1'b0, 3'b000, 1'b0, 3'b100};
    vecs[4] = '{1'b1, 8'h10, 3'b001, 1'b0, 3'b001, 1'b1, 3'b110};
    vecs[5] = '{1'b1, 8'hFE, 3'b100, 1'b0, 3'b100, 1'b1, 3'b011};

    // Reset state, with a header offered during reset.
    rst = 1'b1;
    applyStimulus(1'b1, 8'h39, 3'b000, 3'b111, 3'b111);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset we", bus.write_enb, 0);
    checkOutput("reset lfd", bus.lfd_state, 0);
    checkOutput("reset ld", bus.ld_state, 0);
    checkOutput("reset err", bus.err, 0);
    checkOutput("reset soft", bus.soft_reset, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table: each row is checked from IDLE, then reset covers the next edge.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].pv, vecs[i].d, 3'b000, vecs[i].empty, 3'b111);
      checkOutput($sformatf("vec%0d busy", i), bus.busy, vecs[i].busy);
      checkOutput($sformatf("vec%0d we", i), bus.write_enb, vecs[i].we);
      checkOutput($sformatf("vec%0d lfd", i), bus.lfd_state, vecs[i].lfd);
      checkOutput($sformatf("vec%0d dout", i), bus.dout, vecs[i].d);
      checkOutput($sformatf("vec%0d vld", i), bus.vld_out, vecs[i].vld);
      checkOutput($sformatf("vec%0d ld", i), bus.ld_state, 0);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
    end

    // Full packet, good parity; bad parity; 3-cycle full stall on byte 0x05.
    runPkt(8'h39, -1, 0, 8'h38, 1'b0, "good");
    runPkt(8'h39, -1, 0, 8'h07, 1'b1, "badpar");
    runPkt(8'h39, 6, 3, 8'h38, 1'b0, "stall");

    // Dropped packet to address 3, then a normal packet.
    applyStimulus(1'b1, 8'h0B, 3'b000, 3'b111, 3'b111);
    checkOutput("drop hdr we", bus.write_enb, 0);
    checkOutput("drop hdr busy", bus.busy, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(k), 3'b000, 3'b111, 3'b111);
      checkOutput("drop we", bus.write_enb, 0);
      checkOutput("drop busy", bus.busy, 0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 3'b000, 3'b111, 3'b111);
    checkOutput("drop err", bus.err, 0);
    tick();
    runPkt(8'h04, -1, 0, 8'h04, 1'b0, "after drop");

    // Header to a non-empty FIFO 2; empty rises 5 cycles later.
    applyStimulus(1'b1, 8'h0A, 3'b000, 3'b011, 3'b111);
    checkOutput("wait hdr we", bus.write_enb, 0);
    checkOutput("wait hdr busy", bus.busy, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 8'h55, 3'b000, 3'b011, 3'b111);
      checkOutput("wait busy", bus.busy, 1);
      checkOutput("wait we", bus.write_enb, 0);
      tick();
    end
    applyStimulus(1'b0, 8'h55, 3'b000, 3'b111, 3'b111);
    checkOutput("wait write busy", bus.busy, 1);
    checkOutput("wait write we", bus.write_enb, 3'b100);
    checkOutput("wait write lfd", bus.lfd_state, 1);
    checkOutput("wait write dout", bus.dout, 8'h0A);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, (k == 2) ? 8'h0B : 8'(k), 3'b000, 3'b111, 3'b111);
      checkOutput("wait payload we", bus.write_enb, 3'b100);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 3'b000, 3'b111, 3'b111);
    checkOutput("wait err", bus.err, 0);
    tick();

    // Timeout: FIFO 0 holds data, reader idle for 30 cycles.
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1'b0, 8'h00, 3'b000, 3'b110, 3'b000);
      checkOutput("timeout pre", bus.soft_reset, 0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 3'b000, 3'b110, 3'b000);
    checkOutput("timeout pulse", bus.soft_reset, 3'b001);
    tick();
    applyStimulus(1'b0, 8'h00, 3'b000, 3'b110, 3'b000);
    checkOutput("timeout single", bus.soft_reset, 0);
    tick();
    applyStimulus(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
    tick();
    // Read at cycle 29 restarts the count: no pulse within 40 cycles.
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b0, 8'h00, 3'b000, 3'b110, (k == 29) ? 3'b001 : 3'b000);
      checkOutput("timeout read", bus.soft_reset, 0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 3'b000, 3'b111, 3'b111);
    tick();

    // Reset in the middle of a payload.
    applyStimulus(1'b1, 8'h39, 3'b000, 3'b111, 3'b111);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'(k), 3'b000, 3'b111, 3'b111);
      tick();
    end
    applyStimulus(1'b1, 8'h03, 3'b010, 3'b101, 3'b111);
    checkOutput("midrst pre busy", bus.busy, 1);
    checkOutput("midrst pre ld", bus.ld_state, 1);
    bus.fifo_full  = 3'b000;
    bus.fifo_empty = 3'b111;
    rst = 1'b1;
    #1;
    checkOutput("midrst busy", bus.busy, 0);
    checkOutput("midrst we", bus.write_enb, 0);
    checkOutput("midrst lfd", bus.lfd_state, 0);
    checkOutput("midrst ld", bus.ld_state, 0);
    checkOutput("midrst err", bus.err, 0);
    checkOutput("midrst soft", bus.soft_reset, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    runPkt(8'h04, -1, 0, 8'h04, 1'b0, "after reset");

    randomTest();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL global time limit reached: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] time limit");
  end

endmodule

// File: doc/router_ctrl.md
Name: router_ctrl

Overview:
- Input-side packet controller for the 1x3 router.
- Accepts the serial byte stream of each packet, decodes the destination from the header byte, and sequences writes into one of three router_fifo instances: write enables, first-data flag, data mux.
- Back-pressures the source with busy and checks the trailing parity byte.
- Runs a per-port soft-reset timeout that flushes a destination FIFO its reader has abandoned.

Parameters:
- DATA_W, 8: byte width of the packet stream.
- TIMEOUT, 30: consecutive stalled cycles before a port is soft-reset.
- TO_W, 5: width of each timeout counter; must satisfy 2^TO_W > TIMEOUT-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- pkt_valid  in  1  source byte strobe; a byte is accepted on an edge where pkt_valid=1 and busy=0.
- data_in  in  DATA_W  source byte.
- fifo_full  in  3  full flag of FIFO 0..2.
- fifo_empty  in  3  empty flag of FIFO 0..2.
- read_enb  in  3  destination read enable of FIFO 0..2.
- busy  out  1  combinational; source must hold its byte while busy=1.
- dout  out  DATA_W  combinational; byte presented to all FIFOs: hold_reg when writing a latched header, otherwise data_in.
- write_enb  out  3  combinational one-hot FIFO write enable.
- lfd_state  out  1  combinational; high only in the cycle the header is written.
- ld_state  out  1  high while in LOAD_DATA or LOAD_PARITY.
- err  out  1  registered parity-error pulse.
- vld_out  out  3  ~fifo_empty.
- soft_reset  out  3  registered one-cycle FIFO flush pulses.

Behaviour:
Header format and reset:
- Header byte = {len[7:2], addr[1:0]}. Packet = header, len payload bytes (0..63), one parity byte.
- Expected parity = XOR of the header byte and all payload bytes.
- rst=1 forces: state IDLE, counters 0, hold_reg 0, parity accumulator 0, err=0, soft_reset=0. Outputs then read busy=0, write_enb=0, lfd_state=0, ld_state=0.
- rst asserted mid-packet abandons the packet; no partial-write recovery.

IDLE (busy=0):
- Accepted byte is the header. Latch addr, len, hold_reg=data_in, parity=data_in.
- If addr=3: go to DROP with drop counter=len+1. No write.
- Else if fifo_empty[addr]=1: write the header in the same cycle (write_enb[addr]=1, lfd_state=1, dout=data_in). Next state is LOAD_DATA, or LOAD_PARITY if len=0.
- Else: go to WAIT_EMPTY.

WAIT_EMPTY (busy=1):
- When fifo_empty[addr]=1: write_enb[addr]=1, lfd_state=1, dout=hold_reg. Next state LOAD_DATA, or LOAD_PARITY if len=0.

LOAD_DATA:
- busy=fifo_full[addr].
- Each accepted byte: write_enb[addr]=1, parity^=byte, remaining--.
- Acceptance of the last payload byte goes to LOAD_PARITY.
- While fifo_full[addr]=1: no write and no count change; the byte is held by the source.

LOAD_PARITY:
- busy=fifo_full[addr].
- Accepted byte is written (write_enb[addr]=1), then state returns to IDLE.
- err=1 in the following cycle only if byte != accumulated parity.
- A new header is accepted in the cycle after the parity byte.

DROP (busy=0):
- Consume accepted bytes with no writes. When the drop counter reaches 0, go to IDLE.
- err is never asserted for a dropped packet.

General write rules:
- write_enb is at most one-hot, never asserted while the selected fifo_full=1, and always 0 in DROP and IDLE-with-addr=3.
- pkt_valid=0 in any state: no acceptance, no state change except WAIT_EMPTY->write.

Timeout (ports i=0..2, independent of the packet FSM):
- cnt_i increments on each cycle where vld_out[i]=1 and read_enb[i]=0. It clears on read_enb[i]=1 or fifo_empty[i]=1.
- When cnt_i=TIMEOUT-1 and the stall persists that cycle, soft_reset[i]=1 in the next cycle for exactly 1 cycle, and cnt_i clears.
- A soft reset of the FIFO the FSM is currently filling does not alter FSM state; the rest of the packet is still written.

Test Plan:
- Header 0x39 (len 14, addr 1), FIFO1 empty, payload 0x00..0x0D, parity 0x38, pkt_valid continuous -> write_enb[1] high 16 consecutive cycles, lfd_state high on the header cycle only, ld_state high 15 cycles, err stays 0, back in IDLE.
- Same packet with parity 0x07 -> all 16 bytes written; err=1 for exactly one cycle after the parity byte.
- Same packet, fifo_full[1]=1 for 3 cycles while payload byte 0x05 is presented -> busy=1 and write_enb=0 for 3 cycles; 0x05 written once when full drops; 16 writes total.
- Header 0x0B (len 2, addr 3) plus 3 bytes -> 4 bytes accepted, write_enb stays 000, err=0; the next header is accepted normally.
- fifo_empty[2]=0 when header 0x0A arrives, empty rises 5 cycles later -> busy=1 for those cycles; header written with dout=0x0A and lfd_state=1 while pkt_valid=0.
- FIFO0 non-empty, read_enb[0]=0 for 30 cycles -> soft_reset[0] pulses once in cycle 31. Repeat with read_enb[0]=1 at cycle 29 -> no pulse. rst asserted mid-payload -> all outputs 0 asynchronously, FSM in IDLE.
